// File: rtl/edge_event_if.sv
// Event port between the edge scheduler and its consumer: channel index,
// edge polarity and a valid/ready pair.
interface edge_event_if #(
    parameter int N_CH = 4,
    parameter int ID_W = $clog2(N_CH)
);
    // Handshake: the master raises ev_valid with ev_ch/ev_rise and holds all
    // three stable until ev_ready is seen high on a rising clk edge; the event
    // transfers on exactly that edge. ev_valid never depends on ev_ready.
    logic            ev_valid;
    logic            ev_ready;
    logic [ID_W-1:0] ev_ch;
    logic            ev_rise;

    modport master (
        output ev_valid,
        output ev_ch,
        output ev_rise,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_ch,
        input  ev_rise,
        output ev_ready
    );
endinterface

// File: rtl/edge_event_scheduler.sv
// Dual-edge detector on N_CH synchronous levels, one pending event per channel,
// round-robin serialised onto a single registered valid/ready event port.
module edge_event_scheduler #(
    parameter  int N_CH = 4,
    localparam int ID_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  level,
    edge_event_if.master     ev,
    output logic [N_CH-1:0]  overrun,
    input  logic             overrun_clr
);

    logic [N_CH-1:0] level_q;
    logic [N_CH-1:0] pend;
    logic [N_CH-1:0] pend_rise;
    logic [N_CH-1:0] edge_det;
    logic [N_CH-1:0] pend_nxt;
    logic [N_CH-1:0] pend_rise_nxt;
    logic [N_CH-1:0] ovr_set;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] cand;
    logic            grant_vld;
    logic            slot_free;
    logic            load;

    assign edge_det  = level ^ level_q;
    assign slot_free = !ev.ev_valid || ev.ev_ready;
    assign load      = slot_free && grant_vld;

    // Search starts one past the last granted channel and wraps back to it.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int k = 1; k <= N_CH; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % N_CH);
            if (!grant_vld && pend[cand]) begin
                grant_vld = 1'b1;
                grant_id  = cand;
            end
        end
    end

    // A channel being unloaded this cycle can accept a fresh edge without loss.
    always_comb begin
        pend_nxt      = pend;
        pend_rise_nxt = pend_rise;
        ovr_set       = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (load && (grant_id == ID_W'(i))) begin
                pend_nxt[i] = 1'b0;
            end
            if (edge_det[i]) begin
                if (!pend_nxt[i]) begin
                    pend_nxt[i]      = 1'b1;
                    pend_rise_nxt[i] = level[i];
                end else begin
                    ovr_set[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q     <= '0;
            pend        <= '0;
            pend_rise   <= '0;
            overrun     <= '0;
            rr_ptr      <= ID_W'(N_CH - 1);
            ev.ev_valid <= 1'b0;
            ev.ev_ch    <= '0;
            ev.ev_rise  <= 1'b0;
        end else begin
            level_q   <= level;
            pend      <= pend_nxt;
            pend_rise <= pend_rise_nxt;
            overrun   <= (overrun_clr ? '0 : overrun) | ovr_set;
            if (slot_free) begin
                ev.ev_valid <= grant_vld;
                if (grant_vld) begin
                    ev.ev_ch   <= grant_id;
                    ev.ev_rise <= pend_rise[grant_id];
                    rr_ptr     <= grant_id;
                end
            end
        end
    end

endmodule

// File: tb/tb_edge_event_scheduler.sv
// Randomised and directed bench for edge_event_scheduler with a queue-based
// reference model and a decoupled event monitor.
module tb_edge_event_scheduler;
    localparam int N_CH = 4;
    localparam int ID_W = 2;
    localparam int W    = ID_W + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N_CH-1:0] level = '0;
    logic            overrun_clr = 1'b0;
    logic            ready = 1'b1;
    logic [N_CH-1:0] overrun;

    int total = 0;
    int bad = 0;
    int xfer_cnt = 0;
    int base;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] seen_q[$];

    // reference model state
    logic [N_CH-1:0] m_lq = '0;
    logic [N_CH-1:0] m_pend = '0;
    logic [N_CH-1:0] m_prise = '0;
    logic [N_CH-1:0] m_ovr = '0;
    logic            m_valid = 1'b0;
    int              m_ptr = N_CH - 1;

    edge_event_if #(.N_CH(N_CH)) ev ();
    assign ev.ev_ready = ready;

    edge_event_scheduler #(.N_CH(N_CH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .level       (level),
        .ev          (ev),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required finish before 400000");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_seen(input string name, input int idx, input logic [W-1:0] exp);
        if (idx < seen_q.size()) begin
            chk(name, 32'(seen_q[idx]), 32'(exp));
        end else begin
            total++;
            bad++;
            $display("FAIL %s: got no event at index %0d required %0h", name, idx, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One clock of the behavioural model: grant from the pending set, then
    // apply this cycle's edges against what is still pending.
    task automatic model_step();
        bit   free;
        int   g;
        int   c;
        logic grise;
        free  = !m_valid || ready;
        g     = -1;
        grise = 1'b0;
        if (free) begin
            for (int k = 1; k <= N_CH; k++) begin
                c = (m_ptr + k) % N_CH;
                if (g < 0 && m_pend[c]) g = c;
            end
        end
        if (g >= 0) begin
            grise     = m_prise[g];
            m_pend[g] = 1'b0;
            m_ptr     = g;
        end
        if (overrun_clr) m_ovr = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (level[i] != m_lq[i]) begin
                if (!m_pend[i]) begin
                    m_pend[i]  = 1'b1;
                    m_prise[i] = level[i];
                end else begin
                    m_ovr[i] = 1'b1;
                end
            end
        end
        if (free) begin
            m_valid = (g >= 0);
            if (g >= 0) exp_q.push_back({ID_W'(g), grise});
        end
        m_lq = level;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_lq    = '0;
                m_pend  = '0;
                m_prise = '0;
                m_ovr   = '0;
                m_valid = 1'b0;
                m_ptr   = N_CH - 1;
                exp_q.delete();
            end else begin
                model_step();
            end
        end
    end

    // scoreboard monitor
    initial begin
        logic [W-1:0] exp_ev;
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("ev_valid", 32'(ev.ev_valid), 32'(m_valid));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            if (ev.ev_valid && ev.ev_ready) begin
                xfer_cnt++;
                seen_q.push_back({ev.ev_ch, ev.ev_rise});
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL event: got ch=%0d rise=%0b required no event", ev.ev_ch, ev.ev_rise);
                end else begin
                    exp_ev = exp_q.pop_front();
                    chk("event", 32'({ev.ev_ch, ev.ev_rise}), 32'(exp_ev));
                end
            end
        end
    end

    // stimulus
    initial begin
        tick(10);
        rst_n = 1'b1;
        tick(20);
        chk("idle_xfers", 32'(xfer_cnt), 0);
        chk("idle_overrun", 32'(overrun), 0);

        // single channel
        seen_q.delete();
        level[2] = 1'b1;
        tick(2);
        chk("single_valid", 32'(ev.ev_valid), 1);
        chk("single_ch", 32'(ev.ev_ch), 2);
        chk("single_rise", 32'(ev.ev_rise), 1);
        tick(1);
        chk("single_once", 32'(ev.ev_valid), 0);
        level[2] = 1'b0;
        tick(4);
        chk("single_count", 32'(seen_q.size()), 2);
        chk_seen("single_fall", 1, {2'd2, 1'b0});

        // leave the last grant on channel 3
        level[3] = 1'b1;
        tick(4);
        level[3] = 1'b0;
        tick(4);

        // round-robin on simultaneous edges
        seen_q.delete();
        level = 4'hF;
        tick(8);
        for (int i = 0; i < N_CH; i++) chk_seen("rr_rise", i, {ID_W'(i), 1'b1});
        seen_q.delete();
        level = 4'h0;
        tick(8);
        for (int i = 0; i < N_CH; i++) chk_seen("rr_fall", i, {ID_W'(i), 1'b0});
        level = 4'b0010;
        tick(4);
        seen_q.delete();
        level = 4'b1011;
        tick(5);
        chk("rr_after1_count", 32'(seen_q.size()), 2);
        chk_seen("rr_after1_first", 0, {2'd3, 1'b1});
        chk_seen("rr_after1_second", 1, {2'd0, 1'b1});
        level = 4'b0000;
        tick(6);

        // backpressure
        ready = 1'b0;
        level = 4'b0010;
        tick(3);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 32'(ev.ev_valid), 1);
            chk("bp_ch", 32'(ev.ev_ch), 1);
            chk("bp_rise", 32'(ev.ev_rise), 1);
            tick(1);
        end
        base = xfer_cnt;
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        tick(2);
        chk("bp_one_xfer", 32'(xfer_cnt - base), 1);
        chk("bp_after_valid", 32'(ev.ev_valid), 0);
        ready = 1'b1;
        level = 4'b0000;
        tick(4);

        // overrun
        ready = 1'b0;
        level = 4'b0001;
        tick(1);
        level = 4'b1001;
        tick(1);
        level = 4'b0001;
        tick(3);
        chk("ovr_bits", 32'(overrun), 32'h8);
        chk("ovr_presented_ch", 32'(ev.ev_ch), 0);
        overrun_clr = 1'b1;
        tick(1);
        overrun_clr = 1'b0;
        chk("ovr_clear", 32'(overrun), 0);
        seen_q.delete();
        ready = 1'b1;
        tick(3);
        chk("ovr_count", 32'(seen_q.size()), 2);
        chk_seen("ovr_first", 0, {2'd0, 1'b1});
        chk_seen("ovr_second", 1, {2'd3, 1'b1});
        level = 4'b0000;
        tick(5);

        // reset while events are pending and presented
        ready = 1'b0;
        level = 4'b0111;
        tick(4);
        chk("rst_pre_valid", 32'(ev.ev_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 32'(ev.ev_valid), 0);
        chk("rst_async_overrun", 32'(overrun), 0);
        level = 4'b0000;
        tick(1);
        rst_n = 1'b1;
        ready = 1'b1;
        base = xfer_cnt;
        tick(10);
        chk("rst_no_stale", 32'(xfer_cnt - base), 0);

        // randomised traffic
        for (int n = 0; n < 3000; n++) begin
            ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0)
                level = level ^ N_CH'(1 << $urandom_range(0, N_CH - 1));
            overrun_clr = ($urandom_range(0, 15) == 0);
            tick(1);
        end
        overrun_clr = 1'b0;
        ready = 1'b1;
        tick(20);
        chk("drain_empty", 32'(exp_q.size()), 0);
        chk("drain_valid", 32'(ev.ev_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/edge_event_scheduler.md
# edge_event_scheduler

Multi-channel dual-edge event scheduler. Each of `N_CH` level inputs is dual-edge detected. Each detected edge is held as one pending event per channel. The scheduler then serialises the pending events, round-robin, onto a single valid/ready event port that reports channel index and edge polarity. It sits between the synchronised GPIO/level inputs and the single event-consuming unit (interrupt/logger), which previously needed one `edge_tick` per input.

## Interface
Parameters:
- `N_CH`, 4, number of level channels (2..32)
- `ID_W`, `$clog2(N_CH)`, channel index width (derived, do not override)

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `level`  in  N_CH  per-channel levels, already synchronous to `clk`
- `ev_valid`  out  1  event present on `ev_ch`/`ev_rise`
- `ev_ready`  in  1  consumer accepts event when `ev_valid & ev_ready`
- `ev_ch`  out  ID_W  channel index of presented event
- `ev_rise`  out  1  1 = rising edge, 0 = falling edge
- `overrun`  out  N_CH  sticky per-channel lost-event flags
- `overrun_clr`  in  1  one-cycle pulse, clears all `overrun` bits

## Operation
- Per channel `i`: `level_q[i]` is registered every cycle. Edge when `level[i] != level_q[i]`, polarity = `level[i]`.
- Pending storage per channel: `pend[i]` and `pend_rise[i]`, depth 1.
- Edge on `i` with `pend[i]=0`: set `pend[i]` and `pend_rise[i]=level[i]`.
- Edge on `i` with `pend[i]=1` and `i` not being loaded into the output this cycle: drop the new edge, keep the oldest event, set `overrun[i]`.
- Edge on `i` in the same cycle that `i`'s pending event is loaded into the output: new edge becomes pending, no overrun.
- Output register (1 entry):
  - A slot is free when `!ev_valid`, or when `ev_valid & ev_ready` in this cycle.
  - If the slot is free and any `pend` bit is set, the arbiter grants one channel. It loads `ev_ch`/`ev_rise` from that channel, clears that channel's `pend`, and `ev_valid` is 1 next cycle.
  - If the slot is free and nothing is pending, `ev_valid` goes to 0.
- Arbitration is round-robin. After a grant to `g`, the search order is `g+1, g+2, ... g` mod `N_CH`. The pointer updates only on a grant.
- While `ev_valid & !ev_ready`: `ev_valid`, `ev_ch` and `ev_rise` are held stable.
- `overrun_clr` clears all bits. If a set and `overrun_clr` occur in the same cycle, the set wins for that bit.
- Reset (asynchronous assert, released synchronously upstream):
  - `level_q`, `pend`, `pend_rise`, `ev_valid`, `ev_ch`, `ev_rise` and `overrun` = 0.
  - RR pointer = `N_CH-1`, so channel 0 has highest priority first.
  - Reset mid-transfer discards all pending and presented events.
- Because `level_q` resets to 0, a channel held high through reset release reports one rising event.

## Timing
- Latency: a level change first sampled at rising edge E0 sets `pend` at E0. The grant occurs at E1, and `ev_valid` is high after E1 (2 clocks, level to valid) when the slot is free.
- Throughput: 1 event/cycle with `ev_ready` held high.
- An edge pulse of 1 cycle (e.g. high for 1 clk) yields two events: rise then fall, provided the first is granted before the second edge. Otherwise the second is an overrun.
- No combinational path from `ev_ready` to `ev_valid`, `ev_ch` or `ev_rise`.
- Simultaneous edges on k channels take k consecutive grants in RR order.

## Test plan
- Reset/idle: hold `rst_n=0` for 10 clk, levels 0, then release. Required: `ev_valid=0` and `overrun=0` throughout, with no events for 20 clk.
- Single channel: `level[2]` 0→1, `ev_ready=1`. Required: 2 clk later, one cycle of `ev_valid=1`, `ev_ch=2`, `ev_rise=1`. Then `level[2]` 1→0 gives `ev_ch=2`, `ev_rise=0`.
- Round-robin: all 4 levels rise in the same cycle with `ev_ready=1`. Required: `ev_ch` sequence 0,1,2,3 on 4 consecutive cycles. Repeat with falls after the last grant was 3: sequence 0,1,2,3 again. After a grant to 1, rises on channels 0 and 3 are granted 3 then 0.
- Backpressure: `ev_ready=0`, `level[1]` rises. Required: `ev_valid`, `ev_ch=1` and `ev_rise=1` are held stable for 10 clk. Raising `ev_ready` for 1 clk gives exactly one transfer.
- Overrun: `ev_ready=0`, `level[0]` rises, then `level[3]` rises, then `level[3]` falls. Required: `overrun=4'b1000`, and the presented/pending events are ch0 rise then ch3 rise; the ch3 fall is lost. Then pulse `overrun_clr`: `overrun=0`.
- Reset mid-operation: three events pending with `ev_valid=1`, then assert `rst_n=0` for 1 clk. Required: `ev_valid` drops to 0 immediately (asynchronous), and no stale events appear after release.
